// File: rtl/mem_access_stage.sv
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : MEM stage of the 5-stage pipeline. Resolves branch/jump
//             redirection for IF and performs the data-memory access over a
//             req/ack handshake. Holds the upstream pipeline with a stall
//             while an access is outstanding. Contains the MEM/WB register.
//             All registers update on the falling edge of clk_Mem.
//  Options  : MEM_TIMEOUT_EN - when defined, an access that waits TIMEOUT-1
//             falling edges without ack is aborted and err_out_Mem is set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_Mem,
  input  logic        rst_Mem,
  // EX/MEM register contents
  input  logic [31:0] PC_in_Mem,
  input  logic [31:0] PC4_in_Mem,
  input  logic [31:0] ALU_in_Mem,
  input  logic [31:0] Rs2_in_Mem,
  input  logic [4:0]  Rd_addr_in_Mem,
  input  logic        zero_in_Mem,
  input  logic        MemRW_in_Mem,
  input  logic        Jump_in_Mem,
  input  logic        RegWrite_in_Mem,
  input  logic [1:0]  Branch_in_Mem,
  input  logic [1:0]  MemtoReg_in_Mem,
  // IF redirection and pipeline hold
  output logic        PCSrc_out_Mem,
  output logic [31:0] PC_target_out_Mem,
  output logic        stall_out_Mem,
  // data-memory handshake
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  // sticky status
  output logic        misalign_out_Mem,
  output logic        err_out_Mem,
  // MEM/WB register
  output logic [31:0] ALU_out_MemWB,
  output logic [31:0] MDR_out_MemWB,
  output logic [31:0] PC4_out_MemWB,
  output logic [4:0]  Rd_addr_out_MemWB,
  output logic [1:0]  MemtoReg_out_MemWB,
  output logic        RegWrite_out_MemWB
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Reject out-of-range configurations at elaboration.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range_bad
    $error("mem_access_stage: TIMEOUT must be within 2..255");
  end

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic       w_is_load;
  logic       w_mem_op;
  logic       w_misaligned;
  logic       w_timeout_hit;
  logic       w_stall;
  logic       w_load_done;

  assign w_is_load    = (MemtoReg_in_Mem == 2'b01);
  assign w_mem_op     = w_is_load | MemRW_in_Mem;
  assign w_misaligned = w_mem_op & (ALU_in_Mem[1:0] != 2'b00);

  // Redirection depends only on the EX/MEM contents, so it stays valid
  // through stall cycles because EX/MEM is frozen.
  assign PCSrc_out_Mem = Jump_in_Mem
                       | ((Branch_in_Mem == 2'b01) &  zero_in_Mem)
                       | ((Branch_in_Mem == 2'b10) & ~zero_in_Mem);
  assign PC_target_out_Mem = PC_in_Mem;

  // Address, data and direction come straight from the frozen EX/MEM stage.
  assign dmem_addr  = ALU_in_Mem;
  assign dmem_wdata = Rs2_in_Mem;
  assign dmem_we    = MemRW_in_Mem;

  assign w_stall       = dmem_req & ~dmem_ack & ~w_timeout_hit;
  assign w_load_done   = dmem_req & dmem_ack & w_is_load;
  assign stall_out_Mem = w_stall;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_wait_cnt;
  logic       r_err;

  // Count falling edges spent waiting for ack; cleared whenever not stalled.
  always_ff @(negedge clk_Mem or posedge rst_Mem) begin
    if (rst_Mem) begin
      r_wait_cnt <= 8'd0;
    end else if (w_stall) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  // A late ack still wins; the abort only fires in a cycle without ack.
  assign w_timeout_hit = (r_state == S_WAIT) & ~dmem_ack
                       & (r_wait_cnt == C_TIMEOUT_LAST);

  // Sticky timeout flag.
  always_ff @(negedge clk_Mem or posedge rst_Mem) begin
    if (rst_Mem) begin
      r_err <= 1'b0;
    end else if (w_timeout_hit) begin
      r_err <= 1'b1;
    end
  end

  assign err_out_Mem = r_err;
`else
  assign w_timeout_hit = 1'b0;
  assign err_out_Mem   = 1'b0;
`endif

  // Handshake state register.
  always_ff @(negedge clk_Mem or posedge rst_Mem) begin
    if (rst_Mem) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Enter WAIT on an unacknowledged request; leave on ack or abort.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_stall) w_state_next = S_WAIT;
      S_WAIT:  if (dmem_ack || w_timeout_hit) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request generation; reset removes the request immediately.
  always_comb begin
    dmem_req = 1'b0;
    if (!rst_Mem) begin
      case (r_state)
        S_IDLE:  dmem_req = w_mem_op & ~w_misaligned;
        S_WAIT:  dmem_req = 1'b1;
        default: dmem_req = 1'b0;
      endcase
    end
  end

  // Sticky misaligned-access flag.
  always_ff @(negedge clk_Mem or posedge rst_Mem) begin
    if (rst_Mem) begin
      misalign_out_Mem <= 1'b0;
    end else if (w_misaligned) begin
      misalign_out_Mem <= 1'b1;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the instruction
  // with register write suppressed for misaligned or aborted accesses.
  always_ff @(negedge clk_Mem or posedge rst_Mem) begin
    if (rst_Mem) begin
      ALU_out_MemWB      <= 32'd0;
      MDR_out_MemWB      <= 32'd0;
      PC4_out_MemWB      <= 32'd0;
      Rd_addr_out_MemWB  <= 5'd0;
      MemtoReg_out_MemWB <= 2'b00;
      RegWrite_out_MemWB <= 1'b0;
    end else if (w_stall) begin
      ALU_out_MemWB      <= 32'd0;
      MDR_out_MemWB      <= 32'd0;
      PC4_out_MemWB      <= 32'd0;
      Rd_addr_out_MemWB  <= 5'd0;
      MemtoReg_out_MemWB <= 2'b00;
      RegWrite_out_MemWB <= 1'b0;
    end else begin
      ALU_out_MemWB      <= ALU_in_Mem;
      MDR_out_MemWB      <= w_load_done ? dmem_rdata : 32'd0;
      PC4_out_MemWB      <= PC4_in_Mem;
      Rd_addr_out_MemWB  <= Rd_addr_in_Mem;
      MemtoReg_out_MemWB <= MemtoReg_in_Mem;
      RegWrite_out_MemWB <= RegWrite_in_Mem & ~w_misaligned & ~w_timeout_hit;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench for mem_access_stage. A transaction-level
//             model predicts every output each cycle; directed sequences add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam bit TO_EN      = 1'b1;
`else
  localparam int TB_TIMEOUT = 16;
  localparam bit TO_EN      = 1'b0;
`endif

  logic        clk_Mem;
  logic        rst_Mem;
  logic [31:0] PC_in_Mem, PC4_in_Mem, ALU_in_Mem, Rs2_in_Mem;
  logic [4:0]  Rd_addr_in_Mem;
  logic        zero_in_Mem, MemRW_in_Mem, Jump_in_Mem, RegWrite_in_Mem;
  logic [1:0]  Branch_in_Mem, MemtoReg_in_Mem;
  logic        PCSrc_out_Mem;
  logic [31:0] PC_target_out_Mem;
  logic        stall_out_Mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        misalign_out_Mem, err_out_Mem;
  logic [31:0] ALU_out_MemWB, MDR_out_MemWB, PC4_out_MemWB;
  logic [4:0]  Rd_addr_out_MemWB;
  logic [1:0]  MemtoReg_out_MemWB;
  logic        RegWrite_out_MemWB;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_Mem(clk_Mem), .rst_Mem(rst_Mem),
    .PC_in_Mem(PC_in_Mem), .PC4_in_Mem(PC4_in_Mem),
    .ALU_in_Mem(ALU_in_Mem), .Rs2_in_Mem(Rs2_in_Mem),
    .Rd_addr_in_Mem(Rd_addr_in_Mem), .zero_in_Mem(zero_in_Mem),
    .MemRW_in_Mem(MemRW_in_Mem), .Jump_in_Mem(Jump_in_Mem),
    .RegWrite_in_Mem(RegWrite_in_Mem), .Branch_in_Mem(Branch_in_Mem),
    .MemtoReg_in_Mem(MemtoReg_in_Mem),
    .PCSrc_out_Mem(PCSrc_out_Mem), .PC_target_out_Mem(PC_target_out_Mem),
    .stall_out_Mem(stall_out_Mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .misalign_out_Mem(misalign_out_Mem), .err_out_Mem(err_out_Mem),
    .ALU_out_MemWB(ALU_out_MemWB), .MDR_out_MemWB(MDR_out_MemWB),
    .PC4_out_MemWB(PC4_out_MemWB), .Rd_addr_out_MemWB(Rd_addr_out_MemWB),
    .MemtoReg_out_MemWB(MemtoReg_out_MemWB),
    .RegWrite_out_MemWB(RegWrite_out_MemWB)
  );

  // Falling edges at 5, 15, 25, ...; rising edges are the quiet sample points.
  initial begin
    clk_Mem = 1'b1;
    forever #5 clk_Mem = ~clk_Mem;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_alu, m_mdr, m_pc4;
  logic [4:0]  m_rd;
  logic [1:0]  m_m2r;
  logic        m_rw, m_mis, m_err;
  int          m_waited;   // falling edges the current access has waited

  initial begin
    m_alu = 0; m_mdr = 0; m_pc4 = 0; m_rd = 0; m_m2r = 0;
    m_rw = 0; m_mis = 0; m_err = 0; m_waited = 0;
  end

  function automatic bit f_load();  return MemtoReg_in_Mem == 2'b01; endfunction
  function automatic bit f_memop(); return f_load() || MemRW_in_Mem; endfunction
  function automatic bit f_mis();   return f_memop() && (ALU_in_Mem[1:0] != 2'b00); endfunction
  function automatic bit f_req();   return !rst_Mem && f_memop() && !f_mis(); endfunction
  function automatic bit f_hit();
    return TO_EN && f_req() && !dmem_ack && (m_waited == TB_TIMEOUT - 1);
  endfunction
  function automatic bit f_stall(); return f_req() && !dmem_ack && !f_hit(); endfunction
  function automatic bit f_pcsrc();
    return Jump_in_Mem || (Branch_in_Mem == 2'd1 && zero_in_Mem)
                       || (Branch_in_Mem == 2'd2 && !zero_in_Mem);
  endfunction

  // Model state advances on each falling edge, cleared by reset.
  always @(negedge clk_Mem or posedge rst_Mem) begin
    if (rst_Mem) begin
      m_alu <= 0; m_mdr <= 0; m_pc4 <= 0; m_rd <= 0; m_m2r <= 0;
      m_rw <= 0; m_mis <= 0; m_err <= 0; m_waited <= 0;
    end else begin
      if (f_stall()) begin
        m_alu <= 0; m_mdr <= 0; m_pc4 <= 0; m_rd <= 0; m_m2r <= 0; m_rw <= 0;
        m_waited <= m_waited + 1;
      end else begin
        m_alu    <= ALU_in_Mem;
        m_pc4    <= PC4_in_Mem;
        m_rd     <= Rd_addr_in_Mem;
        m_m2r    <= MemtoReg_in_Mem;
        m_rw     <= RegWrite_in_Mem && !f_mis() && !f_hit();
        m_mdr    <= (f_load() && f_req() && dmem_ack) ? dmem_rdata : 32'd0;
        m_waited <= 0;
        if (f_hit()) m_err <= 1'b1;
      end
      if (f_mis()) m_mis <= 1'b1;
    end
  end

  // Per-cycle comparison at the quiet (rising) edge.
  always @(posedge clk_Mem) begin
    chk("pcsrc",    {31'd0, PCSrc_out_Mem},      {31'd0, f_pcsrc()});
    chk("target",   PC_target_out_Mem,           PC_in_Mem);
    chk("req",      {31'd0, dmem_req},           {31'd0, f_req()});
    chk("stall",    {31'd0, stall_out_Mem},      {31'd0, f_stall()});
    chk("we",       {31'd0, dmem_we},            {31'd0, MemRW_in_Mem});
    chk("addr",     dmem_addr,                   ALU_in_Mem);
    chk("wdata",    dmem_wdata,                  Rs2_in_Mem);
    chk("wb_alu",   ALU_out_MemWB,               m_alu);
    chk("wb_mdr",   MDR_out_MemWB,               m_mdr);
    chk("wb_pc4",   PC4_out_MemWB,               m_pc4);
    chk("wb_rd",    {27'd0, Rd_addr_out_MemWB},  {27'd0, m_rd});
    chk("wb_m2r",   {30'd0, MemtoReg_out_MemWB}, {30'd0, m_m2r});
    chk("wb_rw",    {31'd0, RegWrite_out_MemWB}, {31'd0, m_rw});
    chk("misalign", {31'd0, misalign_out_Mem},   {31'd0, m_mis});
    chk("err",      {31'd0, err_out_Mem},        {31'd0, m_err});
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle(); @(negedge clk_Mem); #1; endtask
  task automatic mid();        @(posedge clk_Mem); #1; endtask

  task automatic set_in(input logic [31:0] pc, pc4, alu, rs2, input logic [4:0] rd,
                        input logic zero, memrw, jump, rw,
                        input logic [1:0] br, m2r);
    PC_in_Mem = pc; PC4_in_Mem = pc4; ALU_in_Mem = alu; Rs2_in_Mem = rs2;
    Rd_addr_in_Mem = rd; zero_in_Mem = zero; MemRW_in_Mem = memrw;
    Jump_in_Mem = jump; RegWrite_in_Mem = rw; Branch_in_Mem = br;
    MemtoReg_in_Mem = m2r;
  endtask

  task automatic branch_case(input logic [1:0] br, input logic zero, jump,
                             input logic exp, input string name);
    set_in(32'h40, 32'h44, 32'h0, 32'h0, 5'd1, zero, 1'b0, jump, 1'b0, br, 2'b00);
    mid();
    chk(name, {31'd0, PCSrc_out_Mem}, {31'd0, exp});
    chk("br_target", PC_target_out_Mem, 32'h40);
    next_cycle();
  endtask

  // Memory access answered after 'waits' stalled cycles; returns just after
  // the completing edge with ack released.
  task automatic access(input logic [31:0] alu, rs2, input logic [4:0] rd,
                        input logic st, rw, input int waits, input logic [31:0] rdata,
                        output int stall_seen, output int bubbles);
    set_in(32'h0, 32'h1000, alu, rs2, rd, 1'b0, st, 1'b0, rw, 2'b00, st ? 2'b00 : 2'b01);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    stall_seen = 0; bubbles = 0;
    for (int i = 0; i < waits; i++) begin
      mid();
      if (stall_out_Mem) stall_seen++;
      next_cycle();
      if (ALU_out_MemWB == 0 && PC4_out_MemWB == 0 && !RegWrite_out_MemWB) bubbles++;
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    mid();
    if (stall_out_Mem) stall_seen++;
    next_cycle();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  initial begin
    int ss, bb, n, guard;
    bit going;
    rst_Mem = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    chk("rst_req",      {31'd0, dmem_req},           32'd0);
    chk("rst_alu",      ALU_out_MemWB,               32'd0);
    chk("rst_rw",       {31'd0, RegWrite_out_MemWB}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_out_Mem},   32'd0);
    chk("rst_err",      {31'd0, err_out_Mem},        32'd0);
    next_cycle();
    rst_Mem = 1'b0;

    // Branch resolution
    branch_case(2'b01, 1'b1, 1'b0, 1'b1, "beq_taken");
    branch_case(2'b10, 1'b1, 1'b0, 1'b0, "bne_not_taken");
    branch_case(2'b10, 1'b0, 1'b0, 1'b1, "bne_taken");
    branch_case(2'b00, 1'b0, 1'b1, 1'b1, "jump");
    branch_case(2'b11, 1'b1, 1'b0, 1'b0, "branch11_none");
    chk("br_pc4_wb", PC4_out_MemWB, 32'h44);

    // Zero-wait load
    set_in(32'h0, 32'h2004, 32'h100, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    mid();
    chk("zw_stall", {31'd0, stall_out_Mem}, 32'd0);
    chk("zw_req",   {31'd0, dmem_req},      32'd1);
    next_cycle();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("zw_mdr", MDR_out_MemWB, 32'hDEADBEEF);
    chk("zw_rw",  {31'd0, RegWrite_out_MemWB}, 32'd1);
    chk("zw_rd",  {27'd0, Rd_addr_out_MemWB},  32'd5);

    // Misaligned load, with a stray ack that must be ignored
    set_in(32'h0, 32'h2008, 32'h102, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    mid();
    chk("mis_req",   {31'd0, dmem_req},      32'd0);
    chk("mis_stall", {31'd0, stall_out_Mem}, 32'd0);
    next_cycle();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("mis_flag", {31'd0, misalign_out_Mem},   32'd1);
    chk("mis_rw",   {31'd0, RegWrite_out_MemWB}, 32'd0);
    chk("mis_mdr",  MDR_out_MemWB,               32'd0);
    chk("mis_alu",  ALU_out_MemWB,               32'h102);

    // Store with 3-cycle memory
    access(32'h104, 32'h12345678, 5'd0, 1'b1, 1'b0, 3, 32'h0, ss, bb);
    chk("st_stalls",  ss, 32'd3);
    chk("st_bubbles", bb, 32'd3);
    chk("st_alu",     ALU_out_MemWB, 32'h104);
    chk("st_rw",      {31'd0, RegWrite_out_MemWB}, 32'd0);

    // Back-to-back loads
    access(32'h200, 32'h0, 5'd8, 1'b0, 1'b1, 1, 32'h11112222, ss, bb);
    chk("b2b_a_mdr", MDR_out_MemWB, 32'h11112222);
    chk("b2b_a_rd",  {27'd0, Rd_addr_out_MemWB}, 32'd8);
    access(32'h204, 32'h0, 5'd9, 1'b0, 1'b1, 0, 32'h33334444, ss, bb);
    chk("b2b_b_stalls", ss, 32'd0);
    chk("b2b_b_mdr",    MDR_out_MemWB, 32'h33334444);
    chk("b2b_b_rd",     {27'd0, Rd_addr_out_MemWB}, 32'd9);

`ifdef MEM_TIMEOUT_EN
    // Access that is never acknowledged
    set_in(32'h0, 32'h3004, 32'h300, 32'h0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    n = 0; guard = 0; going = 1'b1;
    while (going && guard < 10) begin
      mid();
      if (stall_out_Mem) begin
        n++;
        next_cycle();
      end else begin
        going = 1'b0;
      end
      guard++;
    end
    chk("to_dropped", {31'd0, ~going}, 32'd1);
    chk("to_stalls",  n, 32'd3);
    next_cycle();
    chk("to_err", {31'd0, err_out_Mem},        32'd1);
    chk("to_rw",  {31'd0, RegWrite_out_MemWB}, 32'd0);
    chk("to_mdr", MDR_out_MemWB,               32'd0);
    chk("to_alu", ALU_out_MemWB,               32'h300);
    set_in(32'h0, 32'h3008, 32'h77, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    next_cycle();
    chk("to_next_rw",  {31'd0, RegWrite_out_MemWB}, 32'd1);
    chk("to_next_alu", ALU_out_MemWB, 32'h77);
`else
    // Long wait: without the timeout option the access simply persists
    access(32'h300, 32'h0, 5'd10, 1'b0, 1'b1, 20, 32'h9999AAAA, ss, bb);
    chk("lw_stalls", ss, 32'd20);
    chk("lw_err",    {31'd0, err_out_Mem}, 32'd0);
    chk("lw_mdr",    MDR_out_MemWB, 32'h9999AAAA);
`endif

    // Reset while waiting
    set_in(32'h0, 32'h4004, 32'h100, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    dmem_ack = 1'b0;
    mid();
    chk("rw_stall_pre", {31'd0, stall_out_Mem}, 32'd1);
    next_cycle();
    mid();
    #1 rst_Mem = 1'b1;
    #1;
    chk("rw_req",      {31'd0, dmem_req},           32'd0);
    chk("rw_stall",    {31'd0, stall_out_Mem},      32'd0);
    chk("rw_misalign", {31'd0, misalign_out_Mem},   32'd0);
    chk("rw_err",      {31'd0, err_out_Mem},        32'd0);
    chk("rw_rw",       {31'd0, RegWrite_out_MemWB}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    next_cycle();
    rst_Mem = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    mid();
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    next_cycle();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("late_ack_mdr", MDR_out_MemWB, 32'd0);
    chk("late_ack_rw",  {31'd0, RegWrite_out_MemWB}, 32'd0);

    // Plain PC+4 write-back after recovery
    set_in(32'h0, 32'h88, 32'hABC, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10);
    next_cycle();
    chk("fin_pc4", PC4_out_MemWB, 32'h88);
    chk("fin_m2r", {30'd0, MemtoReg_out_MemWB}, 32'd2);
    chk("fin_rw",  {31'd0, RegWrite_out_MemWB}, 32'd1);
    mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
